// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if: request, result and CLA-slice signals of the wide add/sub sequencer.
interface wide_add_seq_if #(
    parameter int SLICE_W    = 16,
    parameter int NUM_SLICES = 4
);
    localparam int DATA_W = SLICE_W * NUM_SLICES;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              ovf;
    logic              zero;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic              slice_cin;
    logic [SLICE_W-1:0] slice_sum;
    logic              slice_cout;

    modport slave (
        input  in_valid, a, b, sub, out_ready, slice_sum, slice_cout,
        output in_ready, out_valid, sum, c_out, ovf, zero, slice_a, slice_b, slice_cin
    );

    modport master (
        output in_valid, a, b, sub, out_ready, slice_sum, slice_cout,
        input  in_ready, out_valid, sum, c_out, ovf, zero, slice_a, slice_b, slice_cin
    );
endinterface

// File: rtl/wide_add_seq.sv
// wide_add_seq: DATA_W-bit add/subtract sequenced LSB-slice first over an external SLICE_W-bit CLA slice.
module wide_add_seq #(
    parameter int SLICE_W    = 16,
    parameter int NUM_SLICES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wide_add_seq_if.slave  bus
);
    localparam int DATA_W = SLICE_W * NUM_SLICES;
    localparam int IDX_W  = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_sum;
    logic              w_run;

    assign w_run = r_state == RUN;

    // b is stored pre-inverted for subtract so the slice always adds; the +1 rides in on carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a        <= bus.a;
                    r_b        <= bus.sub ? ~bus.b : bus.b;
                    r_carry    <= bus.sub;
                    r_idx      <= '0;
                    r_in_ready <= 1'b0;
                    r_state    <= RUN;
                end
                RUN: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= bus.slice_sum;
                    r_carry <= bus.slice_cout;
                    if (r_idx == LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_carry;
    assign bus.zero      = ~|r_sum;
    assign bus.ovf       = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (r_sum[DATA_W-1] != r_a[DATA_W-1]);
    assign bus.slice_a   = w_run ? r_a[r_idx*SLICE_W +: SLICE_W] : '0;
    assign bus.slice_b   = w_run ? r_b[r_idx*SLICE_W +: SLICE_W] : '0;
    assign bus.slice_cin = w_run & r_carry;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed table, corner sequences and random ops against an arithmetic reference model.
module tb_wide_add_seq;
    localparam int SW = 16;
    localparam int NS = 4;
    localparam int DW = SW * NS;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wide_add_seq_if #(.SLICE_W(SW), .NUM_SLICES(NS)) bus ();

    wide_add_seq #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // external combinational CLA slice
    assign {bus.slice_cout, bus.slice_sum} = {1'b0, bus.slice_a} + {1'b0, bus.slice_b} + {{SW{1'b0}}, bus.slice_cin};

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sub;
        logic [DW-1:0] sum;
        logic          c_out;
        logic          ovf;
        logic          zero;
    } vec_t;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, DW'(act), DW'(exp));
    endtask

    task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                         output logic [DW-1:0] sm, output logic co, output logic ov, output logic z);
        logic [DW:0] t;
        logic signed [DW:0] sa, sb, w;
        sm = s ? a - b : a + b;
        t  = {1'b0, a} + {1'b0, b};
        co = s ? (a >= b) : t[DW];
        sa = {a[DW-1], a};
        sb = {b[DW-1], b};
        w  = s ? sa - sb : sa + sb;
        ov = w[DW] != w[DW-1];
        z  = sm == '0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s, output int lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1;
        chk1("in_ready_before_accept", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk1("first_slice_cin", bus.slice_cin, s);
        chk("first_slice_a", DW'(bus.slice_a), DW'(a[SW-1:0]));
        wait_done(lat);
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk1("in_ready_after_release", bus.in_ready, 1'b1);
        chk1("out_valid_after_release", bus.out_valid, 1'b0);
    endtask

    task automatic check_result(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s, input int lat);
        logic [DW-1:0] sm;
        logic co, ov, z;
        model(a, b, s, sm, co, ov, z);
        chk({nm, "_latency"}, DW'(lat), DW'(NS));
        chk({nm, "_sum"}, bus.sum, sm);
        chk1({nm, "_c_out"}, bus.c_out, co);
        chk1({nm, "_ovf"}, bus.ovf, ov);
        chk1({nm, "_zero"}, bus.zero, z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        int lat;
        logic [DW-1:0] a2, b2, held;
        tbl[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk1("reset_in_ready", bus.in_ready, 1'b1);
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_sum", bus.sum, '0);
        chk1("reset_c_out", bus.c_out, 1'b0);
        chk1("reset_ovf", bus.ovf, 1'b0);
        chk1("reset_zero", bus.zero, 1'b1);
        chk("reset_slice_a", DW'(bus.slice_a), '0);
        chk1("reset_slice_cin", bus.slice_cin, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].sub, lat);
            chk("table_latency", DW'(lat), DW'(NS));
            chk("table_sum", bus.sum, tbl[i].sum);
            chk1("table_c_out", bus.c_out, tbl[i].c_out);
            chk1("table_ovf", bus.ovf, tbl[i].ovf);
            chk1("table_zero", bus.zero, tbl[i].zero);
            release_result();
        end

        // backpressure: new request waits while the result is held
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, lat);
        check_result("bp_first", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, lat);
        held = bus.sum;
        a2 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        @(negedge clk);
        bus.a = a2; bus.b = b2; bus.sub = 1'b1; bus.in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk1("bp_in_ready", bus.in_ready, 1'b0);
            chk1("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_sum_held", bus.sum, held);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk1("bp_in_ready_after", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk1("bp_accepted", bus.in_ready, 1'b0);
        wait_done(lat);
        check_result("bp_second", a2, b2, 1'b1, lat);
        release_result();

        // reset during the third RUN cycle
        @(negedge clk);
        bus.a = 64'h0123_4567_89AB_CDEF; bus.b = 64'h1111_2222_3333_4444; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_in_ready", bus.in_ready, 1'b1);
        chk1("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk("rst_mid_sum", bus.sum, '0);
        chk("rst_mid_slice_a", DW'(bus.slice_a), '0);
        chk("rst_mid_slice_b", DW'(bus.slice_b), '0);
        chk1("rst_mid_slice_cin", bus.slice_cin, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk1("rst_no_valid", bus.out_valid, 1'b0);
        end
        run_op(64'd3, 64'd4, 1'b0, lat);
        check_result("rst_fresh", 64'd3, 64'd4, 1'b0, lat);
        chk("rst_fresh_sum7", bus.sum, 64'd7);
        release_result();

        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] ra, rb;
            logic rs;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            if (i % 8 == 1) rb = ra;
            if (i % 8 == 2) ra = '1;
            if (i % 8 == 3) rb = {1'b1, {(DW-1){1'b0}}};
            run_op(ra, rb, rs, lat);
            check_result("random", ra, rb, rs, lat);
            release_result();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
